// File: rtl/mc_seq_ctrl_if.sv
// Handshake bundle between the multi-cycle sequencer and the RV32I datapath/memory ports.
// The sequencer takes the master side; the datapath/memories take the slave side.
interface mc_seq_ctrl_if;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;

    modport master (
        input  opcode, branch_taken, imem_ack, dmem_ack,
        output imem_req, ir_we, dmem_req, dmem_we, reg_write, wb_sel, pc_we, pc_sel
    );
    modport slave (
        output opcode, branch_taken, imem_ack, dmem_ack,
        input  imem_req, ir_we, dmem_req, dmem_we, reg_write, wb_sel, pc_we, pc_sel
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout,
// ECALL/EBREAK halt and cycle/retired-instruction counters.
module mc_seq_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_seq_ctrl_if.master    bus,
    output logic             o_halted,
    output logic             o_bus_err,
    output logic             o_illegal,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret_cnt
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
        MEM  = 3'd4, WB    = 3'd5, HALT   = 3'd6, ERR  = 3'd7
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011, OP_I   = 7'b0010011, OP_L   = 7'b0000011,
                           OP_S   = 7'b0100011, OP_B   = 7'b1100011, OP_J   = 7'b1101111,
                           OP_JR  = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111,
                           OP_SYS = 7'b1110011;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           r_state;
    logic             r_nop;
    logic [WW-1:0]    r_wait;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_ret;

    logic w_known, w_wait_st, w_ack, w_tmo, w_pc_we;

    assign w_known   = bus.opcode inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_J, OP_JR,
                                          OP_LUI, OP_AUI, OP_SYS};
    assign w_wait_st = (r_state == FETCH) || (r_state == MEM);
    assign w_ack     = ((r_state == FETCH) && bus.imem_ack) || ((r_state == MEM) && bus.dmem_ack);
    // An ack arriving in the same cycle the count hits the limit takes priority.
    assign w_tmo     = (TIMEOUT != 0) && w_wait_st && !w_ack && (r_wait == WW'(TIMEOUT - 1));
    assign w_pc_we   = ((r_state == EXEC) && (bus.opcode == OP_B)) ||
                       ((r_state == MEM) && bus.dmem_ack && (bus.opcode == OP_S)) ||
                       (r_state == WB);

    always_comb begin
        bus.imem_req  = (r_state == FETCH);
        bus.ir_we     = (r_state == FETCH) && bus.imem_ack;
        bus.dmem_req  = (r_state == MEM);
        bus.dmem_we   = (r_state == MEM) && (bus.opcode == OP_S);
        bus.reg_write = (r_state == WB) && !r_nop;
        bus.pc_we     = w_pc_we;
        bus.wb_sel    = 2'b00;
        bus.pc_sel    = 2'b00;
        if (r_state == EXEC && bus.opcode == OP_B)
            bus.pc_sel = {1'b0, bus.branch_taken};
        if (r_state == WB && !r_nop) begin
            if (bus.opcode == OP_L)                          bus.wb_sel = 2'b01;
            else if (bus.opcode == OP_J || bus.opcode == OP_JR) bus.wb_sel = 2'b10;
            if (bus.opcode == OP_J)                          bus.pc_sel = 2'b01;
            else if (bus.opcode == OP_JR)                    bus.pc_sel = 2'b10;
        end
    end

    assign o_halted      = (r_state == HALT);
    assign o_bus_err     = (r_state == ERR);
    assign o_illegal     = (r_state == DECODE) && !w_known;
    assign o_state       = r_state;
    assign o_cycle_cnt   = r_cyc;
    assign o_instret_cnt = r_ret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_nop   <= 1'b0;
            r_wait  <= '0;
            r_cyc   <= '0;
            r_ret   <= '0;
        end else begin
            if (r_state inside {FETCH, DECODE, EXEC, MEM, WB})
                r_cyc <= r_cyc + CNT_W'(1);
            if (w_pc_we)
                r_ret <= r_ret + CNT_W'(1);
            // Wait count runs only while stalled on a request; any other cycle clears it.
            r_wait <= (w_wait_st && !w_ack) ? r_wait + WW'(1) : '0;
            case (r_state)
                IDLE:   r_state <= FETCH;
                FETCH:  if (w_ack) r_state <= DECODE;
                        else if (w_tmo) r_state <= ERR;
                DECODE: begin
                    r_nop   <= !w_known;
                    r_state <= w_known ? EXEC : WB;
                end
                EXEC: begin
                    if (bus.opcode == OP_B)                           r_state <= FETCH;
                    else if (bus.opcode == OP_L || bus.opcode == OP_S) r_state <= MEM;
                    else if (bus.opcode == OP_SYS)                    r_state <= HALT;
                    else                                              r_state <= WB;
                end
                MEM:    if (w_ack) r_state <= (bus.opcode == OP_L) ? WB : FETCH;
                        else if (w_tmo) r_state <= ERR;
                WB:     r_state <= FETCH;
                HALT:   r_state <= HALT;
                ERR:    r_state <= ERR;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: per-instruction cycle traces built from the sequencing rules,
// driven into the DUT and compared every cycle, plus literal counter pins.
module tb_mc_seq_ctrl;
    localparam int TMO = 4;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011, S = 7'b0100011,
                           B = 7'b1100011, J = 7'b1101111, JR = 7'b1100111, LUI = 7'b0110111,
                           AUI = 7'b0010111, SYS = 7'b1110011;

    typedef struct {
        logic [6:0] op;
        logic       ia, da, bt;
        logic [2:0] st;
        logic       ireq, irwe, dreq, dwe, rw, pcwe, hlt, berr, ill;
        logic [1:0] wbs, pcs;
        logic       pin;
        int         pc, pr;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hlt, berr, ill;
    logic [2:0]  st;
    logic [31:0] cyc, ret;

    always #5 clk = ~clk;

    mc_seq_ctrl_if bus();

    mc_seq_ctrl #(.TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .o_halted(hlt), .o_bus_err(berr), .o_illegal(ill), .o_state(st),
        .o_cycle_cnt(cyc), .o_instret_cnt(ret)
    );

    rec_t q[$];
    rec_t cur;
    bit   chk_en = 0;
    int   n_chk = 0, n_pass = 0;
    int   m_cyc = 0, m_ret = 0;
    bit   pend = 0;
    int   pend_c, pend_r;

    task automatic chk(string nm, int a, int e);
        n_chk++;
        if (a == e) n_pass++;
        else $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, a, e);
    endtask

    function automatic rec_t mk(logic [2:0] s, logic [6:0] op);
        rec_t r;
        r = '{default: 0};
        r.st = s; r.op = op;
        r.ireq = (s == 3'd1); r.dreq = (s == 3'd4);
        r.hlt  = (s == 3'd6); r.berr = (s == 3'd7);
        return r;
    endfunction

    task automatic pin(int c, int r);
        pend = 1; pend_c = c; pend_r = r;
    endtask

    task automatic push(rec_t r);
        rec_t t;
        t = r;
        if (pend) begin t.pin = 1; t.pc = pend_c; t.pr = pend_r; pend = 0; end
        q.push_back(t);
    endtask

    // Wait-state trace: w idle cycles then ack, or a timeout after TMO cycles without ack.
    task automatic push_wait(logic [2:0] s, logic [6:0] op, int w, output bit err);
        rec_t r;
        err = 0;
        for (int k = 0; k <= w; k++) begin
            r = mk(s, op);
            if (s == 3'd4) r.dwe = (op == S);
            if (k == w) begin
                if (s == 3'd1) begin r.ia = 1; r.irwe = 1; end
                else begin r.da = 1; r.pcwe = (op == S); end
                push(r);
                return;
            end
            push(r);
            if (TMO != 0 && k + 1 == TMO) begin err = 1; return; end
        end
    endtask

    task automatic push_term(logic [2:0] s, logic [6:0] op, int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r = mk(s, op);
            r.ia = 1; r.da = 1;
            push(r);
        end
    endtask

    task automatic add_instr(logic [6:0] op, int iw, int dw, logic bt);
        bit   e;
        rec_t r;
        bit   known;
        known = op inside {R, I, L, S, B, J, JR, LUI, AUI, SYS};
        push_wait(3'd1, op, iw, e);
        if (e) begin push_term(3'd7, op, 3); return; end
        r = mk(3'd2, op); r.ill = !known; push(r);
        if (!known) begin r = mk(3'd5, op); r.pcwe = 1; push(r); return; end
        r = mk(3'd3, op);
        if (op == B) begin r.bt = bt; r.pcwe = 1; r.pcs = {1'b0, bt}; push(r); return; end
        push(r);
        if (op == SYS) begin push_term(3'd6, op, 3); return; end
        if (op == L || op == S) begin
            push_wait(3'd4, op, dw, e);
            if (e) begin push_term(3'd7, op, 3); return; end
            if (op == S) return;
        end
        r = mk(3'd5, op);
        r.rw = 1; r.pcwe = 1;
        r.wbs = (op == L) ? 2'd1 : (op == J || op == JR) ? 2'd2 : 2'd0;
        r.pcs = (op == J) ? 2'd1 : (op == JR) ? 2'd2 : 2'd0;
        push(r);
    endtask

    task automatic run();
        while (q.size() > 0) begin
            @(posedge clk); #1;
            cur = q.pop_front();
            bus.opcode = cur.op; bus.imem_ack = cur.ia;
            bus.dmem_ack = cur.da; bus.branch_taken = cur.bt;
            chk_en = 1;
            @(negedge clk); #1;
        end
        chk_en = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0; chk_en = 0;
        #1;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_dmem_req", bus.dmem_req, 0);
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_pc_we", bus.pc_we, 0);
        chk("rst_ir_we", bus.ir_we, 0);
        chk("rst_pc_sel", bus.pc_sel, 0);
        chk("rst_wb_sel", bus.wb_sel, 0);
        chk("rst_state", st, 0);
        chk("rst_flags", {hlt, berr, ill}, 0);
        chk("rst_cycle_cnt", cyc, 0);
        chk("rst_instret_cnt", ret, 0);
        bus.imem_ack = 0; bus.dmem_ack = 0; bus.branch_taken = 0; bus.opcode = 7'h00;
        @(posedge clk); #1;
        rst = 1; m_cyc = 0; m_ret = 0;
        cur = mk(3'd0, 7'h00); chk_en = 1;
        @(negedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("state", st, cur.st);
            chk("imem_req", bus.imem_req, cur.ireq);
            chk("ir_we", bus.ir_we, cur.irwe);
            chk("dmem_req", bus.dmem_req, cur.dreq);
            if (cur.dreq) chk("dmem_we", bus.dmem_we, cur.dwe);
            chk("reg_write", bus.reg_write, cur.rw);
            if (cur.rw) chk("wb_sel", bus.wb_sel, cur.wbs);
            chk("pc_we", bus.pc_we, cur.pcwe);
            if (cur.pcwe) chk("pc_sel", bus.pc_sel, cur.pcs);
            chk("halted", hlt, cur.hlt);
            chk("bus_err", berr, cur.berr);
            chk("illegal", ill, cur.ill);
            chk("cycle_cnt", cyc, m_cyc);
            chk("instret_cnt", ret, m_ret);
            if (cur.pin) begin
                chk("pin_cycle_cnt", cyc, cur.pc);
                chk("pin_instret_cnt", ret, cur.pr);
            end
            if (cur.st >= 3'd1 && cur.st <= 3'd5) m_cyc++;
            if (cur.pcwe) m_ret++;
        end
    end

    initial begin
        bus.opcode = 7'h00; bus.imem_ack = 0; bus.dmem_ack = 0; bus.branch_taken = 0;
        do_reset();
        add_instr(R, 0, 0, 0);    pin(4, 1);
        add_instr(L, 2, 3, 0);    pin(14, 2);
        add_instr(B, 0, 0, 1);
        add_instr(B, 0, 0, 0);    pin(20, 4);
        add_instr(J, 0, 0, 0);
        add_instr(JR, 0, 0, 0);   pin(28, 6);
        add_instr(SYS, 0, 0, 0);  pin(31, 6);
        push(mk(3'd6, SYS));
        run();
        do_reset();
        add_instr(7'h00, 0, 0, 0); pin(3, 1);
        add_instr(S, 0, 100, 0);   pin(10, 1);
        push(mk(3'd7, S));
        run();
        do_reset();
        push(mk(3'd1, R)); push(mk(3'd1, R));
        run();
        do_reset();
        add_instr(LUI, 1, 0, 0);  pin(5, 1);
        push(mk(3'd1, R));
        run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout expected completion", $time);
        $fatal(1);
    end
endmodule
